serial_add_sub: RTL and testbench
=================================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
- REQ-001: Parameter WIDTH shall default to 8 and give the operand and result width in bits; legal range is 2..32.
- REQ-002: Port clk, input, 1 bit: single clock; all state changes on the rising edge.
- REQ-003: Port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-004: Port start, input, 1 bit: request to begin an operation; sampled on the rising edge of clk.
- REQ-005: Port op, input, 1 bit: operation select; 0 = add (a+b), 1 = subtract (a-b); sampled with start.
- REQ-006: Port a, input, WIDTH bits: first operand, unsigned, sampled with start.
- REQ-007: Port b, input, WIDTH bits: second operand, unsigned, sampled with start.
- REQ-008: Port busy, output, 1 bit: high while an operation is in progress.
- REQ-009: Port done, output, 1 bit: one-cycle pulse marking result valid.
- REQ-010: Port result, output, WIDTH bits: sum or difference.
- REQ-011: Port cout, output, 1 bit: final carry-out (add) or final borrow-out (subtract).

Function
- REQ-012: The block shall implement a three-state FSM: IDLE, RUN and DONE.
- REQ-013: In IDLE, start=1 shall capture a, b and op, clear the bit index, and preset the carry/borrow flop to 0; the FSM shall then move to RUN.
- REQ-014: In RUN, the block shall process exactly one bit per cycle, LSB first, through a single 1-bit full-adder or full-subtractor cell selected by the captured op.
- REQ-015: The add cell shall compute sum = a^b^c and c' = ab | c(a^b).
- REQ-016: The subtract cell shall compute diff = a^b^c and c' = (~a&b) | (~(a^b)&c).
- REQ-017: Each RUN cycle shall shift the result bit into result from the MSB side, so that after WIDTH cycles result[0] holds bit 0.
- REQ-018: After the WIDTH-th RUN cycle, the FSM shall enter DONE.
- REQ-019: DONE shall last exactly one cycle, with done=1.
- REQ-020: From DONE, the FSM shall go to IDLE, or directly to RUN if start=1 in that cycle; in the RUN case, new operands are captured as in REQ-013.
- REQ-021: Latency: start sampled at edge N shall produce done=1 in the cycle following edge N+WIDTH+1, i.e. WIDTH+1 cycles after acceptance.
- REQ-022: busy shall be high exactly while the FSM is in RUN.
- REQ-023: start while busy=1 shall be ignored, with no effect on the operands, index or result.
- REQ-024: result and cout shall update only at the end of an operation and shall hold their values until the next operation completes.
- REQ-025: Intermediate shift-register contents shall not be visible on result; a separate output register shall load at the RUN->DONE transition.
- REQ-026: In add mode, cout shall equal bit WIDTH of a+b.
- REQ-027: In subtract mode, cout shall be 1 if and only if a<b (unsigned); result shall be (a-b) mod 2^WIDTH.
- REQ-028: op, a and b changing while busy=1 shall not affect the operation in progress.

Reset
- REQ-029: rst_n=0 shall immediately, without a clock, force the FSM to IDLE and set busy=0, done=0, result=0, cout=0, and clear the internal operand, index and carry registers.
- REQ-030: Reset asserted mid-operation shall abort the operation; no done pulse shall follow after deassertion.
- REQ-031: The first start shall be accepted on the first rising edge at which rst_n=1 and start=1.

Verification (WIDTH=8)
- REQ-032: Add with carry: start, op=0, a=0xFF, b=0x01 -> busy high for 8 cycles, done pulse 9 cycles after acceptance, result=0x00, cout=1.
- REQ-033: Subtract with borrow: op=1, a=0x05, b=0x07 -> result=0xFE, cout=1; then op=1, a=0x80, b=0x80 -> result=0x00, cout=0.
- REQ-034: Exhaustive check at WIDTH=4: all 16x16 operand pairs in both modes shall match a behavioural a+b and a-b, including the cout values.
- REQ-035: Busy rejection: during an add of 0x12+0x34, apply start with a=0xAA, b=0x55, op=1 on cycle 3 -> result=0x46, cout=0, exactly one done pulse.
- REQ-036: Back-to-back: start held high through DONE with new operands 0x10-0x01 -> second done exactly 9 cycles after the first, result=0x0F, cout=0.
- REQ-037: Reset mid-op: assert rst_n=0 on RUN cycle 4 -> outputs read 0 asynchronously, no done pulse after release, and the next operation 0x03+0x04 gives result=0x07.

Source files
------------

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial unsigned adder / subtractor. One operation computes a+b or a-b
//   one bit per clock, LSB first, through a single 1-bit full-adder or
//   full-subtractor cell. The answer is published in a dedicated output
//   register, so partial shift-register contents never appear on result.
//
// Parameters
//   WIDTH   operand / result width in bits (2..32)
//
// Ports
//   clk     clock, rising-edge active
//   rst_n   asynchronous active-low reset
//   start   begin an operation (ignored while busy)
//   op      0 = add, 1 = subtract (sampled with start)
//   a, b    unsigned operands (sampled with start)
//   busy    high while the bit-serial datapath is running
//   done    one-cycle pulse: result / cout hold the new answer
//   result  sum or difference, held until the next operation completes
//   cout    carry-out (add) or borrow-out (subtract)
// -----------------------------------------------------------------------------
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             op_q,     op_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] shift_q,  shift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             cell_sum_s;
    logic             cell_carry_s;
    logic [WIDTH-1:0] shift_next_s;

    // Shared 1-bit cell: operands are shifted right each cycle, so bit 0 is
    // always the current bit. Sum and difference use the same XOR chain.
    always_comb begin
        cell_sum_s = a_q[0] ^ b_q[0] ^ carry_q;
        if (op_q == 1'b0) begin
            cell_carry_s = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        end else begin
            cell_carry_s = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & carry_q);
        end
        // New bit enters from the MSB side; after WIDTH shifts bit 0 is at [0].
        shift_next_s = {cell_sum_s, shift_q[WIDTH-1:1]};
    end

    // Next-state and next-output logic for the IDLE / RUN / DONE sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        shift_d  = shift_q;
        result_d = result_q;
        cout_d   = cout_q;
        busy_d   = 1'b0;
        // The done pulse follows the single DONE cycle by one clock.
        done_d   = (state_q == S_DONE) ? 1'b1 : 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start == 1'b1) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    idx_d   = {IDX_W{1'b0}};
                    carry_d = 1'b0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = cell_carry_s;
                shift_d = shift_next_s;
                idx_d   = idx_q + IDX_ONE;
                if (idx_q == IDX_LAST) begin
                    // Final bit: publish the whole word and the last carry.
                    result_d = shift_next_s;
                    cout_d   = cell_carry_s;
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                end else begin
                    state_d  = S_RUN;
                    busy_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            op_q     <= 1'b0;
            idx_q    <= {IDX_W{1'b0}};
            carry_q  <= 1'b0;
            shift_q  <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            shift_q  <= shift_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
//   Drives an 8-bit and a 4-bit instance. A cycle-level model derived from the
//   operation timing (acceptance edge, WIDTH busy cycles, done one cycle later)
//   and plain integer arithmetic predicts every output on every cycle; directed
//   sequences additionally pin hand-computed results and latencies.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start_i;
    logic [1:0] op_i;
    logic [7:0] a0, b0, r0;
    logic [3:0] a1, b1, r1;
    logic [1:0] busy_o, done_o, cout_o;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .op(op_i[0]),
        .a(a0), .b(b0), .busy(busy_o[0]), .done(done_o[0]),
        .result(r0), .cout(cout_o[0])
    );

    serial_add_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .op(op_i[1]),
        .a(a1), .b(b1), .busy(busy_o[1]), .done(done_o[1]),
        .result(r1), .cout(cout_o[1])
    );

    function automatic int wid(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic int a_val(input int k);
        return (k == 0) ? int'(a0) : int'(a1);
    endfunction

    function automatic int b_val(input int k);
        return (k == 0) ? int'(b0) : int'(b1);
    endfunction

    function automatic int r_val(input int k);
        return (k == 0) ? int'(r0) : int'(r1);
    endfunction

    // {cout, result} from integer arithmetic.
    function automatic logic [8:0] calc(input int w, input logic opv, input int av, input int bv);
        int m;
        int r;
        m = 1 << w;
        if (opv == 1'b0) begin
            r = av + bv;
            return {(r >= m) ? 1'b1 : 1'b0, 8'(r % m)};
        end else begin
            r = av - bv;
            if (r < 0) r = r + m;
            return {(av < bv) ? 1'b1 : 1'b0, 8'(r)};
        end
    endfunction

    // ---------------- cycle-level model ----------------
    int         cyc = 0;
    int         acc[2];
    bit         has_op[2];
    int         done_at[2];
    logic [7:0] pend_res[2];
    logic       pend_cout[2];
    logic [7:0] exp_res[2];
    logic       exp_cout[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            for (int k = 0; k < 2; k++) begin
                has_op[k]    <= 1'b0;
                acc[k]       <= 0;
                done_at[k]   <= -100;
                pend_res[k]  <= 8'h00;
                pend_cout[k] <= 1'b0;
                exp_res[k]   <= 8'h00;
                exp_cout[k]  <= 1'b0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < 2; k++) begin
                if (has_op[k] && (cyc + 1 == acc[k] + wid(k))) begin
                    exp_res[k]  <= pend_res[k];
                    exp_cout[k] <= pend_cout[k];
                    done_at[k]  <= cyc + 2;
                end
                if (start_i[k] && !(has_op[k] && (cyc + 1 > acc[k]) && (cyc + 1 <= acc[k] + wid(k)))) begin
                    has_op[k] <= 1'b1;
                    acc[k]    <= cyc + 1;
                    {pend_cout[k], pend_res[k]} <= calc(wid(k), op_i[k], a_val(k), b_val(k));
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t: got 0x%0h expected 0x%0h", name, k, $time, act, exp_v);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("busy", k, 32'(busy_o[k]),
                    32'(has_op[k] && (cyc >= acc[k]) && (cyc < acc[k] + wid(k))));
                chk("done", k, 32'(done_o[k]), 32'(cyc == done_at[k]));
                chk("result", k, r_val(k), 32'(exp_res[k]));
                chk("cout", k, 32'(cout_o[k]), 32'(exp_cout[k]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input int k, input logic st, input logic opv, input int av, input int bv);
        start_i[k] = st;
        op_i[k]    = opv;
        if (k == 0) begin
            a0 = 8'(av);
            b0 = 8'(bv);
        end else begin
            a1 = 4'(av);
            b1 = 4'(bv);
        end
    endtask

    // Called at a negedge that is j0 cycles after acceptance; returns cycles
    // to done and number of busy cycles seen on the way.
    task automatic wait_done(input int k, input int j0, output int j, output int nb);
        j  = j0;
        nb = 0;
        while (!done_o[k] && j < 40) begin
            if (busy_o[k]) nb++;
            @(negedge clk);
            j++;
        end
        if (!done_o[k]) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout dut%0d: got no done expected done within 40 cycles", k);
        end
    endtask

    task automatic run_op(input int k, input logic opv, input int av, input int bv,
                          input logic [7:0] er, input logic ec, input bit rel, input string name);
        int j;
        int nb;
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        set_in(k, 1'b1, opv, av, bv);
        @(negedge clk);
        start_i[k] = 1'b0;
        wait_done(k, 0, j, nb);
        chk({name, "_latency"}, k, j, wid(k) + 1);
        chk({name, "_busycyc"}, k, nb, wid(k));
        chk({name, "_res"}, k, r_val(k), 32'(er));
        chk({name, "_cout"}, k, 32'(cout_o[k]), 32'(ec));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        int nb;
        int nd;
        logic [8:0] e;
        rst_n = 1'b0;
        set_in(0, 1'b0, 1'b0, 0, 0);
        set_in(1, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("rst_done", 0, 32'(done_o[0]), 32'd0);
        chk("rst_result", 0, r_val(0), 32'd0);
        chk("rst_cout", 0, 32'(cout_o[0]), 32'd0);

        // Start presented together with reset release: accepted at first edge.
        run_op(0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, "add_ff_01");
        run_op(0, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, "sub_05_07");
        run_op(0, 1'b1, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, "sub_80_80");
        run_op(0, 1'b0, 8'h3C, 8'h5A, 8'h96, 1'b0, 1'b0, "add_3c_5a");

        // Start while busy is ignored.
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 8'h12, 8'h34);
        @(negedge clk);
        start_i[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        set_in(0, 1'b1, 1'b1, 8'hAA, 8'h55);
        @(negedge clk);
        start_i[0] = 1'b0;
        wait_done(0, 3, j, nb);
        chk("busyrej_latency", 0, j, 9);
        chk("busyrej_res", 0, r_val(0), 32'h46);
        chk("busyrej_cout", 0, 32'(cout_o[0]), 32'd0);
        nd = 1;
        repeat (12) begin
            @(negedge clk);
            if (done_o[0]) nd++;
        end
        chk("busyrej_pulses", 0, nd, 1);

        // Back-to-back: start held through DONE with new operands.
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 8'h20, 8'h22);
        @(negedge clk);
        set_in(0, 1'b1, 1'b1, 8'h10, 8'h01);
        wait_done(0, 0, j, nb);
        start_i[0] = 1'b0;
        chk("b2b_first_res", 0, r_val(0), 32'h42);
        @(negedge clk);
        wait_done(0, 1, j, nb);
        chk("b2b_gap", 0, j, 9);
        chk("b2b_res", 0, r_val(0), 32'h0F);
        chk("b2b_cout", 0, 32'(cout_o[0]), 32'd0);

        // Reset in the 4th RUN cycle.
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 8'h55, 8'h11);
        @(negedge clk);
        start_i[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("arst_done", 0, 32'(done_o[0]), 32'd0);
        chk("arst_result", 0, r_val(0), 32'd0);
        chk("arst_cout", 0, 32'(cout_o[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_o[0]) nd++;
        end
        chk("arst_nodone", 0, nd, 0);
        run_op(0, 1'b0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, "add_03_04");

        // Exhaustive 4-bit sweep, both modes.
        for (int opv = 0; opv < 2; opv++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    e = calc(4, 1'(opv), av, bv);
                    run_op(1, 1'(opv), av, bv, e[7:0], e[8], 1'b0, "w4");
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
